// File: rtl/scale_select_arbiter.sv
// Round-robin arbiter sharing one scale_freq_select between the autotune voice (0)
// and the harmony voice (1); returns the selector's frequency over a req/ack handshake.
module scale_select_arbiter #(
    parameter int TIMEOUT = 1024,
    parameter int FREQ_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [11:0]       scale,
    input  logic              req0,
    input  logic              req1,
    input  logic [3:0]        note_name0,
    input  logic [3:0]        note_name1,
    input  logic [2:0]        note_octave0,
    input  logic [2:0]        note_octave1,
    input  logic              greater0,
    input  logic              greater1,
    output logic              ack0,
    output logic              ack1,
    output logic [FREQ_W-1:0] freq0,
    output logic [FREQ_W-1:0] freq1,
    output logic              err0,
    output logic              err1,
    output logic [3:0]        sel_note_name,
    output logic [2:0]        sel_note_octave,
    output logic              sel_greater,
    output logic [11:0]       sel_scale,
    output logic              sel_start,
    input  logic              sel_done,
    input  logic [FREQ_W-1:0] sel_freq_desired,
    output logic              busy
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    logic            last_grant;
    logic            grant;
    logic [CW-1:0]   count;

    logic            pick;
    logic [3:0]      pick_name;
    logic [2:0]      pick_octave;
    logic            pick_greater;

    // On a tie the requester that was not served last wins; otherwise the lone requester.
    always_comb begin
        pick         = (req0 && req1) ? ~last_grant : req1;
        pick_name    = pick ? note_name1   : note_name0;
        pick_octave  = pick ? note_octave1 : note_octave0;
        pick_greater = pick ? greater1     : greater0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            last_grant      <= 1'b1;
            grant           <= 1'b0;
            count           <= '0;
            ack0            <= 1'b0;
            ack1            <= 1'b0;
            freq0           <= '0;
            freq1           <= '0;
            err0            <= 1'b0;
            err1            <= 1'b0;
            sel_note_name   <= '0;
            sel_note_octave <= '0;
            sel_greater     <= 1'b0;
            sel_scale       <= '0;
            sel_start       <= 1'b0;
            busy            <= 1'b0;
        end else begin
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            sel_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant           <= pick;
                        sel_note_name   <= pick_name;
                        sel_note_octave <= pick_octave;
                        sel_greater     <= pick_greater;
                        sel_scale       <= scale;
                        busy            <= 1'b1;
                        if (pick_name > 4'd11) begin
                            // Out-of-range note is answered without touching the selector.
                            state <= RESP;
                            if (pick) begin
                                ack1  <= 1'b1;
                                err1  <= 1'b1;
                                freq1 <= '0;
                            end else begin
                                ack0  <= 1'b1;
                                err0  <= 1'b1;
                                freq0 <= '0;
                            end
                        end else begin
                            state     <= ISSUE;
                            sel_start <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    count <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // Done wins over the timeout when both happen on the last cycle.
                    if (sel_done || count == CW'(TIMEOUT - 1)) begin
                        state <= RESP;
                        if (grant) begin
                            ack1  <= 1'b1;
                            err1  <= ~sel_done;
                            freq1 <= sel_done ? sel_freq_desired : '0;
                        end else begin
                            ack0  <= 1'b1;
                            err0  <= ~sel_done;
                            freq0 <= sel_done ? sel_freq_desired : '0;
                        end
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                RESP: begin
                    last_grant <= grant;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
